// File: rtl/obstacle_spawner.sv
// Obstacle spawn controller: arms the down counter with a random interval,
// then emits a spawn pulse with a random obstacle type when it expires.
module obstacle_spawner #(
  parameter int          COUNT_W   = 9,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int          HOLDOFF   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear_stats,
  input  logic [COUNT_W-1:0] count,
  output logic               load_en,
  output logic [1:0]         load_value,
  output logic               spawn,
  output logic [1:0]         obstacle_type,
  output logic [7:0]         spawned_count,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    WATCH,
    SPAWN
  } state_t;

  // An all-zero seed would lock the LFSR up forever.
  localparam logic [7:0] SEED =
    (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);
  localparam bit SKIP_HOLD = (HOLDOFF == 0);

  state_t     state;
  state_t     state_d;
  logic [7:0] lfsr;
  logic [7:0] lfsr_d;
  logic [3:0] holdcnt;
  logic [3:0] holdcnt_d;
  logic [7:0] cnt_d;
  logic [1:0] type_d;

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] v
  );
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always_comb begin
    state_d   = state;
    lfsr_d    = lfsr;
    holdcnt_d = holdcnt;
    cnt_d     = spawned_count;
    type_d    = obstacle_type;

    unique case (state)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        holdcnt_d = HOLD_INIT;
        state_d   = SKIP_HOLD ? WATCH : HOLD;
      end
      HOLD: begin
        if (holdcnt != 4'd0) holdcnt_d = holdcnt - 4'd1;
        // Dropping enable aborts; otherwise wait out the stale count.
        if (!enable)
          state_d = IDLE;
        else if (holdcnt <= 4'd1)
          state_d = WATCH;
      end
      WATCH: begin
        if (!enable)
          state_d = IDLE;
        else if (count == '0)
          state_d = SPAWN;
      end
      SPAWN: begin
        lfsr_d  = lfsr_step(lfsr);
        state_d = enable ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == SPAWN) begin
      type_d = lfsr[3:2];
      cnt_d  = (spawned_count == 8'hFF) ?
               8'hFF : spawned_count + 8'd1;
    end

    // Clearing beats a coincident increment.
    if (clear_stats) cnt_d = 8'h00;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lfsr          <= SEED;
      holdcnt       <= 4'd0;
      load_en       <= 1'b0;
      load_value    <= 2'b00;
      spawn         <= 1'b0;
      obstacle_type <= 2'b00;
      spawned_count <= 8'h00;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      lfsr          <= lfsr_d;
      holdcnt       <= holdcnt_d;
      load_en       <= (state_d == LOAD);
      load_value    <= (state_d == LOAD) ?
                       lfsr_d[1:0] : 2'b00;
      spawn         <= (state_d == SPAWN);
      obstacle_type <= type_d;
      spawned_count <= cnt_d;
      busy          <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Scoreboard bench for obstacle_spawner: expected loads and spawns are
// queued as stimulus is driven and retired by a negedge monitor.
module tb_obstacle_spawner;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       clear_stats;
  logic [8:0] count;
  logic       load_en;
  logic [1:0] load_value;
  logic       spawn;
  logic [1:0] obstacle_type;
  logic [7:0] spawned_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] load_q[$];
  logic [9:0] spawn_q[$];
  logic [7:0] m_lfsr;
  logic [7:0] m_cnt;

  obstacle_spawner #(
    .COUNT_W(9),
    .LFSR_SEED(8'hA5),
    .HOLDOFF(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .clear_stats(clear_stats),
    .count(count),
    .load_en(load_en),
    .load_value(load_value),
    .spawn(spawn),
    .obstacle_type(obstacle_type),
    .spawned_count(spawned_count),
    .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] step(
    input logic [7:0] v
  );
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  task automatic push_load();
    load_q.push_back(m_lfsr[1:0]);
  endtask

  task automatic push_spawn(input bit clr);
    if (clr)
      m_cnt = 8'h00;
    else if (m_cnt != 8'hFF)
      m_cnt = m_cnt + 8'd1;
    spawn_q.push_back({m_lfsr[3:2], m_cnt});
    m_lfsr = step(m_lfsr);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (load_en) begin
        if (load_q.size() == 0)
          chk("load_unexpected", 1, 0);
        else
          chk("load_value", load_value, load_q.pop_front());
      end else begin
        chk("load_value_idle", load_value, 0);
      end
      if (spawn) begin
        if (spawn_q.size() == 0)
          chk("spawn_unexpected", 1, 0);
        else
          chk("spawn_type_cnt",
              {obstacle_type, spawned_count},
              spawn_q.pop_front());
      end
    end
  end

  task automatic wait_load(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!load_en && n < maxc);
    chk("load_seen", load_en, 1);
  endtask

  task automatic wait_spawn(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!spawn && n < maxc);
    chk("spawn_seen", spawn, 1);
  endtask

  function automatic logic [14:0] outs();
    return {load_en, load_value, spawn, obstacle_type,
            spawned_count, busy};
  endfunction

  initial begin
    int n;
    reset       = 1'b1;
    enable      = 1'b0;
    clear_stats = 1'b0;
    count       = 9'd5;
    m_lfsr      = 8'hA5;
    m_cnt       = 8'h00;

    repeat (2) @(negedge clock);
    chk("reset_outs", outs(), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_outs", outs(), 0);

    // First interval, then a back-to-back second one with count held at 0.
    enable = 1'b1;
    push_load();
    wait_load(10, n);
    chk("lat_enable", n, 1);
    chk("busy_load", busy, 1);
    repeat (6) @(negedge clock);
    count = 9'd0;
    push_spawn(0);
    push_load();
    push_spawn(0);
    wait_spawn(10, n);
    chk("lat_spawn", n, 1);
    wait_load(10, n);
    chk("lat_reload", n, 1);
    wait_spawn(20, n);
    chk("holdoff_gap", n, 4);
    enable = 1'b0;
    @(negedge clock);
    chk("busy_off", busy, 0);

    // Abort in WATCH with count==0 on the same edge.
    count  = 9'd5;
    enable = 1'b1;
    push_load();
    wait_load(10, n);
    repeat (4) @(negedge clock);
    chk("busy_watch", busy, 1);
    enable = 1'b0;
    count  = 9'd0;
    repeat (3) @(negedge clock);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", spawned_count, m_cnt);
    count  = 9'd5;
    enable = 1'b1;
    push_load();
    wait_load(10, n);
    chk("lat_reenable", n, 1);

    // Run past 255 spawns to reach saturation.
    for (int i = 0; i < 260; i++) begin
      push_spawn(0);
      if (i == 0) count = 9'd0;
      wait_spawn(20, n);
      if (i == 259) begin
        enable = 1'b0;
      end else begin
        push_load();
        wait_load(5, n);
      end
    end
    @(negedge clock);
    chk("sat_cnt", spawned_count, 8'hFF);

    // Asynchronous reset in the middle of a LOAD cycle.
    count  = 9'd5;
    enable = 1'b1;
    push_load();
    wait_load(10, n);
    chk("pre_reset_cnt", spawned_count, 8'hFF);
    #1 reset = 1'b1;
    #1 chk("async_reset", outs(), 0);
    enable = 1'b0;
    m_lfsr = 8'hA5;
    m_cnt  = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("post_reset", outs(), 0);

    // Fresh seed, holdoff masking, then clear coinciding with a spawn.
    count  = 9'd0;
    enable = 1'b1;
    push_load();
    wait_load(10, n);
    push_spawn(0);
    wait_spawn(20, n);
    chk("mask_gap", n, 4);
    push_load();
    wait_load(5, n);
    repeat (3) @(negedge clock);
    clear_stats = 1'b1;
    push_spawn(1);
    wait_spawn(5, n);
    chk("clr_spawn_lat", n, 1);
    enable = 1'b0;
    @(negedge clock);
    clear_stats = 1'b0;
    chk("clr_cnt", spawned_count, 0);
    chk("clr_spawn_off", spawn, 0);

    chk("load_q_empty", load_q.size(), 0);
    chk("spawn_q_empty", spawn_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Initiator-side controller for the obstacle down counter.
- Issues one-cycle load_en/load_value commands to the counter, then watches the counter's count bus and raises a one-cycle spawn pulse when it reaches zero.
- Each spawn carries a pseudo-random obstacle_type; the block immediately re-arms the counter with a new pseudo-random interval.
- Sits between the game-control logic (enable, clear_stats) and the down counter; spawn feeds the obstacle renderer.

Parameters:
- COUNT_W, 9, width of the count bus from the down counter.
- LFSR_SEED, 8'hA5, reset value of the 8-bit LFSR. A value of 0 is replaced by 8'h01.
- HOLDOFF, 2, cycles spent in HOLD after a load before count is examined. Range 0..15; 0 skips HOLD.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run request, level-sensitive, synchronous to clock.
- clear_stats  input  1  synchronous clear of spawned_count.
- count  input  COUNT_W  current value of the down counter.
- load_en  output  1  one-cycle load command to the down counter.
- load_value  output  2  interval code driven with load_en; 0 whenever load_en=0.
- spawn  output  1  one-cycle obstacle pulse.
- obstacle_type  output  2  type of the most recent spawn; holds its value between spawns.
- spawned_count  output  8  number of spawns since reset or clear, saturating.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, high): state=IDLE, lfsr=LFSR_SEED (or 8'h01 if the seed is 0), holdcnt=0. All outputs are 0.
- All outputs are registered. An output value listed for a state is present during the cycle the block is in that state.
- IDLE: outputs are 0 and busy=0. If enable=1, next state is LOAD.
- LOAD (exactly one cycle):
  - load_en=1, load_value=lfsr[1:0].
  - holdcnt is loaded with HOLDOFF.
  - Next state is HOLD, or WATCH if HOLDOFF=0.
  - load_en is issued even if enable falls during this cycle.
- HOLD: holdcnt decrements each cycle. When holdcnt reaches 1 (or is already 0), next state is WATCH. This masks the stale count from before the load.
- WATCH:
  - If count==0, next state is SPAWN.
  - Otherwise the block stays in WATCH.
  - There is no timeout; a stalled counter holds the block in WATCH indefinitely.
- SPAWN (exactly one cycle):
  - spawn=1; obstacle_type is updated to lfsr[3:2], captured on entry to SPAWN.
  - spawned_count increments, saturating at 8'hFF.
  - At the end of the cycle the LFSR advances one step.
  - Next state is LOAD if enable=1, else IDLE.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. It advances only on exit from SPAWN.
- enable=0 while in HOLD or WATCH: next state is IDLE. No spawn, no LFSR advance, spawned_count unchanged. enable=0 takes priority over count==0.
- enable re-asserted after an abort: the sequence restarts at LOAD with the unchanged LFSR.
- clear_stats=1 sets spawned_count to 0 on the next edge. If it coincides with SPAWN, the clear wins (result 0); spawn and obstacle_type are still produced.
- Reset asserted mid-operation: all state and outputs return to reset values immediately, with no dependency on the clock.
- Latency:
  - enable sampled high in IDLE → load_en asserted 1 cycle later.
  - count==0 sampled in WATCH → spawn asserted 1 cycle later.
  - End of SPAWN → next load_en 1 cycle later when enable=1.

Test Plan:
- Reset check: assert reset mid-run → all outputs read 0 in the same cycle, before any clock edge. After release, with enable=0, they stay 0.
- First cycle, HOLDOFF=2, seed A5:
  - Stimulus: raise enable at edge 0; drive count=0 from edge 5.
  - Required: load_en=1 with load_value=2'b01 during cycle 1; busy=1.
  - Required: spawn=1 exactly one cycle after the first WATCH cycle that samples count=0, obstacle_type=2'b01, spawned_count=1.
- Second cycle: with enable still high → next load_en the cycle after spawn, with load_value=2'b10 (LFSR=8'h4A). The following spawn gives obstacle_type=2'b10 and spawned_count=2.
- Holdoff masking: hold count=0 continuously through LOAD and HOLD → no spawn until WATCH. Spawn occurs exactly HOLDOFF+2 cycles after load_en.
- Abort: drop enable while in WATCH with count=0 on the same edge → state returns to IDLE, no spawn, spawned_count unchanged. Re-enable → load_value equals the pre-abort value.
- Saturation and clear:
  - Force 260 spawns → spawned_count stays at 8'hFF.
  - Assert clear_stats coincident with a spawn → spawn=1 and spawned_count=0 on the next cycle.
